// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------
// Consumer side of the program-counter interface. Owns the fetch address,
// drives a synchronous instruction memory and hands each fetched word, together
// with its PC, to decode over a valid/ready handshake. Execute can redirect the
// fetch stream (branch/jump) or ask it to halt after the current instruction.
//
// Each instruction takes three cycles:
//   FETCH : issue the memory read for fetch_pc
//   WAIT  : read data returns and is captured into instr
//   HOLD  : instr is presented to decode until instr_ready is seen
//
// Ports:
//   clk          system clock, all state changes on posedge
//   rst          synchronous active-high reset
//   redirect     one-cycle pulse: restart fetching at redirect_pc
//   redirect_pc  redirect target (not alignment-checked)
//   halt         one-cycle pulse: stop after the instruction in progress
//   imem_en      memory read enable (FETCH only)
//   imem_addr    memory read address
//   imem_data    memory read data, valid the cycle after imem_en
//   instr        fetched instruction
//   instr_pc     address of instr
//   instr_valid  instr/instr_pc valid
//   instr_ready  decode accepts instr this cycle
//   next_pc      address of the next instruction to fetch (PC register input)
//   halted       sequencer is stopped in HALT
module fetch_sequencer #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          PC_INC   = 1,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] next_pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
    logic              halt_pend, halt_pend_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic [ADDR_W-1:0] instr_pc_nxt;
    logic              instr_valid_nxt;

    // Outputs depend only on state, so decode never sees a combinational
    // path from its own ready back into the memory interface.
    assign imem_en   = (state == FETCH);
    assign imem_addr = fetch_pc;
    assign next_pc   = fetch_pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            pend_pc     <= '0;
            halt_pend   <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            pend_pc     <= pend_pc_nxt;
            halt_pend   <= halt_pend_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        pend_pc_nxt     = pend_pc;
        halt_pend_nxt   = halt_pend;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;

        case (state)
            FETCH: begin
                // Remember which address the in-flight read belongs to; the
                // increment wraps naturally at the register width.
                pend_pc_nxt  = fetch_pc;
                fetch_pc_nxt = fetch_pc + ADDR_W'(PC_INC);
                state_nxt    = WAIT;
                if (halt) halt_pend_nxt = 1'b1;
            end
            WAIT: begin
                instr_nxt       = imem_data;
                instr_pc_nxt    = pend_pc;
                instr_valid_nxt = 1'b1;
                state_nxt       = HOLD;
                if (halt) halt_pend_nxt = 1'b1;
            end
            HOLD: begin
                if (instr_ready) begin
                    instr_valid_nxt = 1'b0;
                    halt_pend_nxt   = 1'b0;
                    state_nxt       = (halt_pend || halt) ? HALT : FETCH;
                end else if (halt) begin
                    // A halt arriving while decode stalls must not be lost.
                    halt_pend_nxt = 1'b1;
                end
            end
            HALT: begin
                instr_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        // A redirect overrides whatever the state decided: any read in flight
        // is abandoned (its data is never loaded), a held instruction is
        // squashed unless consumed this same cycle, and a pending halt is
        // cancelled because it referred to the old instruction stream.
        if (redirect) begin
            fetch_pc_nxt    = redirect_pc;
            state_nxt       = FETCH;
            halt_pend_nxt   = 1'b0;
            instr_nxt       = instr;
            instr_pc_nxt    = instr_pc;
            instr_valid_nxt = 1'b0;
        end
    end

endmodule
